// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared constants for the single-port SRAM init/arbitration controller.
package ct_f_spsram_ctrl_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned ADDR_WIDTH_DFLT = 9;
  localparam int unsigned DEPTH_DFLT      = depth_of(ADDR_WIDTH_DFLT);

endpackage

// File: rtl/ct_f_spsram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, pointer is the last winner.
module ct_f_rr_arb2
  import ct_f_spsram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = (last_gnt == PORT1);
        gnt1 = (last_gnt == PORT0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Reset to PORT1 so that port0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT1;
    end else if (gnt0) begin
      last_gnt <= PORT0;
    end else if (gnt1) begin
      last_gnt <= PORT1;
    end
  end

endmodule

// File: rtl/ct_f_spsram_ctrl.sv
// Initialises a single-port SRAM after reset/flush, then shares it between two
// requesters with round-robin arbitration and one-cycle read return.
module ct_f_spsram_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 59,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  flush_req,
  output logic                  init_done,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wmask0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wmask1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned           DEPTH    = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  arb_en;
  logic                  rvalid0_p1;
  logic                  rvalid1_p1;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_IDX) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (flush_req) begin
            state <= ST_INIT;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign init_done = (state == ST_READY);
  assign arb_en    = (state == ST_READY) && !flush_req;

  ct_f_rr_arb2 u_arb (
    .clk   (forever_cpuclk),
    .rst_n (cpurst_b),
    .en    (arb_en),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // SRAM port mux; held idle while reset is asserted so the macro sees no access.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = INIT_VAL;
    if (cpurst_b) begin
      if (state == ST_INIT) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt;
        sram_d    = INIT_VAL;
      end else if (gnt0) begin
        sram_cen  = 1'b0;
        sram_a    = addr0;
        sram_d    = wdata0;
        if (we0) begin
          sram_gwen = 1'b0;
          sram_wen  = ~wmask0;
        end
      end else if (gnt1) begin
        sram_cen  = 1'b0;
        sram_a    = addr1;
        sram_d    = wdata1;
        if (we1) begin
          sram_gwen = 1'b0;
          sram_wen  = ~wmask1;
        end
      end
    end
  end

  // ---- stage p1: SRAM Q is valid the cycle after a granted read ----
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
    end else begin
      rvalid0_p1 <= gnt0 && !we0;
      rvalid1_p1 <= gnt1 && !we1;
    end
  end

  assign rvalid0 = rvalid0_p1;
  assign rvalid1 = rvalid1_p1;
  assign rdata   = sram_q;

endmodule

// File: tb/tb_ct_f_spsram_ctrl.sv
// Scoreboard bench for ct_f_spsram_ctrl with a behavioural 512x59 SRAM attached.
module tb_ct_f_spsram_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 59;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          flush_req = 1'b0;
  logic          init_done;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wmask0 = '0, wdata1 = '0, wmask1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d;
  logic [DW-1:0] sram_q;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic          last_gwen;
  logic [DW-1:0] last_wen;

  always #5 clk = ~clk;

  ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VAL('0)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .flush_req      (flush_req),
    .init_done      (init_done),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .wmask0         (wmask0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .wmask1         (wmask1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rvalid0        (rvalid0),
    .rvalid1        (rvalid1),
    .rdata          (rdata),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural single-port SRAM: per-bit active-low write enables, registered Q.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every read return is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rvalid_port", {62'd0, rvalid1, rvalid0}, (e.port == 1) ? 64'd2 : 64'd1);
        chk("rdata", {5'd0, rdata}, {5'd0, e.data});
      end
    end
  end

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                       input logic [DW-1:0] exp_rd);
    int   n;
    logic g, o;
    n = 0;
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; wmask0 = wm; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; wmask1 = wm; end
    do begin
      @(negedge clk);
      g = (p == 0) ? gnt0 : gnt1;
      o = (p == 0) ? gnt1 : gnt0;
      n++;
    end while (g !== 1'b1 && n < 1000);
    chk("grant", {63'd0, g}, 64'd1);
    chk("other_grant", {63'd0, o}, 64'd0);
    last_gwen = sram_gwen;
    last_wen  = sram_wen;
    if (g === 1'b1 && !we) exp_q.push_back('{p, exp_rd});
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic sweep(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
          sram_a !== i[AW-1:0] || sram_d !== '0 || gnt0 !== 1'b0 ||
          gnt1 !== 1'b0 || init_done !== 1'b0) begin
        if (bad == 0) $display("%s: init sweep deviates at cycle %0d (a=%0h cen=%b)", tag, i, sram_a, sram_cen);
        bad++;
      end
    end
    chk({tag, "_sweep_bad_cycles"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a read request held to prove INIT ignores it.
    req0 = 1'b1; we0 = 1'b0; addr0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    chk("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    chk("rst_cen_gwen", {62'd0, sram_cen, sram_gwen}, 64'd3);
    chk("rst_wen", {5'd0, sram_wen}, {5'd0, {DW{1'b1}}});
    @(posedge clk); #1 cpurst_b = 1'b1;

    sweep("boot");
    @(negedge clk);
    chk("boot_init_done", {63'd0, init_done}, 64'd1);
    chk("boot_first_gnt0", {63'd0, gnt0}, 64'd1);
    if (gnt0 === 1'b1) exp_q.push_back('{0, '0});
    @(posedge clk); #1 req0 = 1'b0;

    // Full write by port0 then immediate read by port1.
    issue(0, 1'b1, 9'h1A5, 59'h5A5A5A5A5A5A5A5, {DW{1'b1}}, '0);
    issue(1, 1'b0, 9'h1A5, '0, '0, 59'h5A5A5A5A5A5A5A5);

    // Masked write, read back, then a zero-mask write must change nothing.
    issue(0, 1'b1, 9'h003, {DW{1'b1}}, 59'h00000000000000F, '0);
    issue(0, 1'b0, 9'h003, '0, '0, 59'h00000000000000F);
    issue(1, 1'b1, 9'h003, '0, '0, '0);
    chk("noop_gwen", {63'd0, last_gwen}, 64'd0);
    chk("noop_wen", {5'd0, last_wen}, {5'd0, {DW{1'b1}}});
    issue(1, 1'b0, 9'h003, '0, '0, 59'h00000000000000F);

    // Both ports requesting: last grant was port1, so 0,1,0,1.
    issue(0, 1'b1, 9'h010, 59'h111, {DW{1'b1}}, '0);
    issue(1, 1'b1, 9'h020, 59'h222, {DW{1'b1}}, '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h020;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", {62'd0, gnt1, gnt0}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) exp_q.push_back('{0, 59'h111});
      else            exp_q.push_back('{1, 59'h222});
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;

    // Flush during a port0 read stream.
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h1A5;
    @(negedge clk);
    chk("pre_flush_gnt0", {63'd0, gnt0}, 64'd1);
    if (gnt0 === 1'b1) exp_q.push_back('{0, 59'h5A5A5A5A5A5A5A5});
    @(posedge clk); #1 flush_req = 1'b1;
    @(negedge clk);
    chk("flush_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    chk("flush_cen", {63'd0, sram_cen}, 64'd1);
    @(posedge clk); #1 flush_req = 1'b0;
    sweep("flush");
    @(negedge clk);
    chk("flush_init_done", {63'd0, init_done}, 64'd1);
    chk("flush_reread_gnt0", {63'd0, gnt0}, 64'd1);
    if (gnt0 === 1'b1) exp_q.push_back('{0, '0});
    @(posedge clk); #1 req0 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of INIT (init_cnt = 200).
    #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("mid_init_addr", 64'(sram_a), 64'd200);
    cpurst_b = 1'b0;
    #1;
    chk("async_rst_cen_gwen", {62'd0, sram_cen, sram_gwen}, 64'd3);
    chk("async_rst_wen", {5'd0, sram_wen}, {5'd0, {DW{1'b1}}});
    chk("async_rst_init_done", {63'd0, init_done}, 64'd0);
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    sweep("rerst");
    @(negedge clk);
    chk("rerst_init_done", {63'd0, init_done}, 64'd1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
